// File: rtl/instr_register_pkg.sv
// Shared types for the instruction register: opcodes, operand/result widths
// and the stored instruction record.
package instr_register_pkg;

    localparam int unsigned OPW  = 32;
    localparam int unsigned RESW = 2 * OPW;

    typedef enum logic [3:0] {
        ZERO  = 4'd0,
        PASSA = 4'd1,
        PASSB = 4'd2,
        ADD   = 4'd3,
        SUB   = 4'd4,
        MULT  = 4'd5,
        DIV   = 4'd6,
        MOD   = 4'd7
    } opcode_t;

    typedef logic signed [OPW-1:0]  operand_t;
    typedef logic signed [RESW-1:0] result_t;

    typedef struct packed {
        opcode_t  opc;
        operand_t op_a;
        operand_t op_b;
        result_t  res;
    } instruction_t;

endpackage

// File: rtl/instr_exec.sv
// Combinational execute stage: evaluates the opcode on sign-extended operands
// at double width so products and quotients never overflow.
module instr_exec
    import instr_register_pkg::*;
#(
    parameter int unsigned OP_WIDTH = OPW
) (
    input  opcode_t                       opcode,
    input  logic signed [OP_WIDTH-1:0]    a,
    input  logic signed [OP_WIDTH-1:0]    b,
    output logic signed [2*OP_WIDTH-1:0]  result,
    output logic                          div0,
    output logic                          illegal
);

    localparam int unsigned RES_W = 2 * OP_WIDTH;

    logic signed [RES_W-1:0] w_a;
    logic signed [RES_W-1:0] w_b;

    assign w_a = {{OP_WIDTH{a[OP_WIDTH-1]}}, a};
    assign w_b = {{OP_WIDTH{b[OP_WIDTH-1]}}, b};

    // Opcode decode; divide by zero and unknown opcodes yield zero plus a flag
    always_comb begin
        result  = '0;
        div0    = 1'b0;
        illegal = 1'b0;
        case (opcode)
            ZERO:  result = '0;
            PASSA: result = w_a;
            PASSB: result = w_b;
            ADD:   result = w_a + w_b;
            SUB:   result = w_a - w_b;
            MULT:  result = w_a * w_b;
            DIV: begin
                if (w_b == '0) div0   = 1'b1;
                else           result = w_a / w_b;
            end
            MOD: begin
                if (w_b == '0) div0   = 1'b1;
                else           result = w_a % w_b;
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/instr_register_ex.sv
// Instruction register: DEPTH entries written with their execute result,
// registered read with valid strobe, occupancy count and sticky error flags.
// OP_WIDTH must equal the package operand width since the stored record
// type comes from the package.
module instr_register_ex
    import instr_register_pkg::*;
#(
    parameter int unsigned OP_WIDTH = OPW,
    parameter int unsigned DEPTH    = 32,
    parameter int unsigned ADDR_W   = $clog2(DEPTH),
    parameter bit          AUTO_INC = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_en,
    input  opcode_t           opcode,
    input  operand_t          operand_a,
    input  operand_t          operand_b,
    input  logic [ADDR_W-1:0] write_pointer,
    input  logic              read_en,
    input  logic [ADDR_W-1:0] read_pointer,
    output instruction_t      instruction_word,
    output logic              rd_valid,
    output logic [ADDR_W-1:0] wr_ptr_q,
    output logic [ADDR_W:0]   entries,
    output logic              div_err,
    output logic              illegal_op
);

    instruction_t      r_mem [DEPTH];
    logic [DEPTH-1:0]  r_valid;
    instruction_t      r_rd_word;
    logic              r_rd_valid;
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W:0]   r_entries;
    logic              r_div_err;
    logic              r_illegal;

    logic [ADDR_W-1:0] w_wr_addr;
    result_t           w_res;
    logic              w_div0;
    logic              w_illegal;
    instruction_t      w_wr_entry;
    instruction_t      w_rd_entry;

    instr_exec #(
        .OP_WIDTH (OP_WIDTH)
    ) u_exec (
        .opcode  (opcode),
        .a       (operand_a),
        .b       (operand_b),
        .result  (w_res),
        .div0    (w_div0),
        .illegal (w_illegal)
    );

    // Write target and the record that would be stored this cycle
    always_comb begin
        w_wr_addr       = AUTO_INC ? r_wr_ptr : write_pointer;
        w_wr_entry.opc  = opcode;
        w_wr_entry.op_a = operand_a;
        w_wr_entry.op_b = operand_b;
        w_wr_entry.res  = w_res;
        w_rd_entry      = r_valid[read_pointer] ? r_mem[read_pointer] : '0;
    end

    // Storage, valid bits, write pointer and occupancy
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= '0;
            end
            r_valid   <= '0;
            r_wr_ptr  <= '0;
            r_entries <= '0;
        end else if (load_en) begin
            r_mem[w_wr_addr]   <= w_wr_entry;
            r_valid[w_wr_addr] <= 1'b1;
            if (!r_valid[w_wr_addr]) begin
                r_entries <= r_entries + (ADDR_W+1)'(1);
            end
            if (AUTO_INC) begin
                r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
            end
        end
    end

    // Registered read; sampled before this edge's write lands (read-before-write)
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_word  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= read_en;
            if (read_en) begin
                r_rd_word <= w_rd_entry;
            end
        end
    end

    // Sticky error flags, cleared only by reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_div_err <= 1'b0;
            r_illegal <= 1'b0;
        end else if (load_en) begin
            if (w_div0)    r_div_err <= 1'b1;
            if (w_illegal) r_illegal <= 1'b1;
        end
    end

    assign instruction_word = r_rd_word;
    assign rd_valid         = r_rd_valid;
    assign wr_ptr_q         = r_wr_ptr;
    assign entries          = r_entries;
    assign div_err          = r_div_err;
    assign illegal_op       = r_illegal;

endmodule

// File: tb/tb_instr_register_ex.sv
// Scoreboard bench: a direct-addressed instance (DEPTH 32) and an
// auto-increment instance (DEPTH 4) share clock and reset.
module tb_instr_register_ex;
    import instr_register_pkg::*;

    typedef struct packed {
        instruction_t iw;
        logic [5:0]   ent;
        logic [5:0]   wptr;
        logic         de;
        logic         il;
    } exp_t;

    logic clk;
    logic reset;

    logic         l0, re0;
    logic [3:0]   op0;
    operand_t     a0, b0;
    logic [4:0]   wp0, rp0;
    instruction_t iw0;
    logic         v0, de0, io0;
    logic [4:0]   wq0;
    logic [5:0]   en0;

    logic         l1, re1;
    logic [3:0]   op1;
    operand_t     a1, b1;
    logic [1:0]   wp1, rp1;
    instruction_t iw1;
    logic         v1, de1, io1;
    logic [1:0]   wq1;
    logic [2:0]   en1;

    exp_t q0[$];
    exp_t q1[$];
    int   checks = 0;
    int   errors = 0;

    instr_register_ex #(.DEPTH(32), .AUTO_INC(1'b0)) dut0 (
        .clk(clk), .reset(reset), .load_en(l0), .opcode(opcode_t'(op0)),
        .operand_a(a0), .operand_b(b0), .write_pointer(wp0), .read_en(re0),
        .read_pointer(rp0), .instruction_word(iw0), .rd_valid(v0),
        .wr_ptr_q(wq0), .entries(en0), .div_err(de0), .illegal_op(io0)
    );

    instr_register_ex #(.DEPTH(4), .AUTO_INC(1'b1)) dut1 (
        .clk(clk), .reset(reset), .load_en(l1), .opcode(opcode_t'(op1)),
        .operand_a(a1), .operand_b(b1), .write_pointer(wp1), .read_en(re1),
        .read_pointer(rp1), .instruction_word(iw1), .rd_valid(v1),
        .wr_ptr_q(wq1), .entries(en1), .div_err(de1), .illegal_op(io1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic void chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    function automatic instruction_t mk(input logic [3:0] op, input operand_t a, input operand_t b, input result_t r);
        instruction_t t;
        t.opc  = opcode_t'(op);
        t.op_a = a;
        t.op_b = b;
        t.res  = r;
        return t;
    endfunction

    // Monitor for the direct-addressed instance
    always @(negedge clk) begin
        if (v0 === 1'b1) begin
            exp_t e;
            if (q0.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL dut0 unexpected rd_valid: got word %h expected no strobe", iw0);
            end else begin
                e = q0.pop_front();
                chk("dut0 word", 160'(iw0), 160'(e.iw));
                chk("dut0 status", 160'({en0, 1'b0, wq0, de0, io0}),
                    160'({e.ent, e.wptr, e.de, e.il}));
            end
        end
    end

    // Monitor for the auto-increment instance
    always @(negedge clk) begin
        if (v1 === 1'b1) begin
            exp_t e;
            if (q1.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL dut1 unexpected rd_valid: got word %h expected no strobe", iw1);
            end else begin
                e = q1.pop_front();
                chk("dut1 word", 160'(iw1), 160'(e.iw));
                chk("dut1 status", 160'({3'b0, en1, 4'b0, wq1, de1, io1}),
                    160'({e.ent, e.wptr, e.de, e.il}));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push0(input instruction_t iw, input int ent, input logic de, input logic il);
        exp_t e;
        e.iw = iw; e.ent = 6'(ent); e.wptr = 6'd0; e.de = de; e.il = il;
        q0.push_back(e);
    endtask

    task automatic wr0(input logic [3:0] op, input operand_t a, input operand_t b, input logic [4:0] addr);
        l0 = 1'b1; op0 = op; a0 = a; b0 = b; wp0 = addr;
        tick();
        l0 = 1'b0;
    endtask

    task automatic rd0(input logic [4:0] addr, input instruction_t iw, input int ent, input logic de, input logic il);
        re0 = 1'b1; rp0 = addr;
        push0(iw, ent, de, il);
        tick();
        re0 = 1'b0;
    endtask

    task automatic wr1(input logic [3:0] op, input operand_t a, input operand_t b);
        l1 = 1'b1; op1 = op; a1 = a; b1 = b; wp1 = 2'd3;
        tick();
        l1 = 1'b0;
    endtask

    task automatic rd1(input logic [1:0] addr, input instruction_t iw, input int ent, input int wptr);
        exp_t e;
        e.iw = iw; e.ent = 6'(ent); e.wptr = 6'(wptr); e.de = 1'b0; e.il = 1'b0;
        q1.push_back(e);
        re1 = 1'b1; rp1 = addr;
        tick();
        re1 = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        l0 = 0; re0 = 0; op0 = '0; a0 = '0; b0 = '0; wp0 = '0; rp0 = '0;
        l1 = 0; re1 = 0; op1 = '0; a1 = '0; b1 = '0; wp1 = '0; rp1 = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        tick();

        // Mid-stream reset: a write, then a read request aborted by reset
        wr0(ADD, 1, 1, 5'd0);
        re0 = 1'b1; rp0 = 5'd0;
        #2;
        reset = 1'b1;
        re0 = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        chk("reset word0", 160'(iw0), 160'(0));
        chk("reset valid0", 160'(v0), 160'(0));
        chk("reset entries0", 160'(en0), 160'(0));
        chk("reset flags0", 160'({de0, io0}), 160'(0));
        chk("reset wptr1", 160'(wq1), 160'(0));
        tick();
        rd0(5'd0, mk(4'd0, 0, 0, 0), 0, 1'b0, 1'b0);

        // Arithmetic, error flags, read-before-write, overflow-free multiply
        wr0(ADD, 5, -3, 5'd2);
        rd0(5'd2, mk(ADD, 5, -3, 2), 1, 1'b0, 1'b0);
        wr0(DIV, 7, 0, 5'd4);
        rd0(5'd4, mk(DIV, 7, 0, 0), 2, 1'b1, 1'b0);
        wr0(4'd9, 3, 4, 5'd5);
        rd0(5'd5, mk(4'd9, 3, 4, 0), 3, 1'b1, 1'b1);
        wr0(SUB, 10, 4, 5'd3);
        l0 = 1'b1; op0 = MULT; a0 = 3; b0 = 4; wp0 = 5'd3;
        re0 = 1'b1; rp0 = 5'd3;
        push0(mk(SUB, 10, 4, 6), 4, 1'b1, 1'b1);
        tick();
        l0 = 1'b0; re0 = 1'b0;
        rd0(5'd3, mk(MULT, 3, 4, 12), 4, 1'b1, 1'b1);
        wr0(MULT, 32'h8000_0000, -1, 5'd6);
        rd0(5'd6, mk(MULT, 32'h8000_0000, -1, 64'h0000_0000_8000_0000), 5, 1'b1, 1'b1);
        wr0(DIV, -7, 2, 5'd7);
        wr0(MOD, -7, 2, 5'd8);
        rd0(5'd7, mk(DIV, -7, 2, -3), 7, 1'b1, 1'b1);
        rd0(5'd8, mk(MOD, -7, 2, -1), 7, 1'b1, 1'b1);
        wr0(PASSB, 11, -9, 5'd31);
        rd0(5'd31, mk(PASSB, 11, -9, -9), 8, 1'b1, 1'b1);
        rd0(5'd30, mk(4'd0, 0, 0, 0), 8, 1'b1, 1'b1);
        wr0(PASSA, -4, 1, 5'd2);
        rd0(5'd2, mk(PASSA, -4, 1, -4), 8, 1'b1, 1'b1);

        // Auto-increment with wrap and saturating occupancy
        wr1(ADD, 1, 0);
        wr1(ADD, 2, 0);
        wr1(ADD, 3, 0);
        rd1(2'd0, mk(ADD, 1, 0, 1), 3, 3);
        wr1(ADD, 4, 0);
        wr1(ADD, 5, 0);
        rd1(2'd0, mk(ADD, 5, 0, 5), 4, 1);
        rd1(2'd1, mk(ADD, 2, 0, 2), 4, 1);
        rd1(2'd3, mk(ADD, 4, 0, 4), 4, 1);

        repeat (3) tick();
        chk("dut0 pending reads", 160'(q0.size()), 160'(0));
        chk("dut1 pending reads", 160'(q1.size()), 160'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
